vload_slot_seq: RTL

VLOAD_SLOT_SEQ -- requirements
Module: vload_slot_seq

---
 rtl/vload_slot_seq_if.sv | 36 +++
 rtl/vload_slot_seq.sv | 138 +++++++++++++
 2 files changed

// File: rtl/vload_slot_seq_if.sv
// Bundles the allocation, response and register-write signals of the
// vector-load slot sequencer. The master side issues loads and returns beats;
// the slave side is the sequencer itself.
interface vload_slot_seq_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_SLOTS  = 4,
  parameter int BEAT_WIDTH = 4
);
  localparam int SLOT_W = $clog2(NUM_SLOTS);

  logic                  flush;
  logic                  alloc_valid;
  logic                  alloc_ready;
  logic [ADDR_WIDTH-1:0] alloc_vd;
  logic [1:0]            alloc_lmul;
  logic [BEAT_WIDTH-1:0] alloc_beats;
  logic [SLOT_W-1:0]     alloc_slot;
  logic                  rsp_valid;
  logic [SLOT_W-1:0]     rsp_slot;
  logic                  wr_valid;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [SLOT_W-1:0]     wr_slot;
  logic                  wr_last;
  logic                  rsp_err;
  logic [NUM_SLOTS-1:0]  busy;

  modport master (
    output flush, alloc_valid, alloc_vd, alloc_lmul, alloc_beats, rsp_valid, rsp_slot,
    input  alloc_ready, alloc_slot, wr_valid, wr_addr, wr_slot, wr_last, rsp_err, busy
  );

  modport slave (
    input  flush, alloc_valid, alloc_vd, alloc_lmul, alloc_beats, rsp_valid, rsp_slot,
    output alloc_ready, alloc_slot, wr_valid, wr_addr, wr_slot, wr_last, rsp_err, busy
  );
endinterface

// File: rtl/vload_slot_seq.sv
// Vector-load slot sequencer. Each slot tracks one outstanding load to a
// register group: every returned beat becomes a registered register-file write,
// stepping through beats per register and then through the registers of the
// group, wrapping the register address at 2^ADDR_WIDTH.
module vload_slot_seq #(
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_SLOTS  = 4,
  parameter int BEAT_WIDTH = 4
) (
  input logic             clk,
  input logic             rst,
  vload_slot_seq_if.slave bus
);
  localparam int SLOT_W = $clog2(NUM_SLOTS);

  logic [NUM_SLOTS-1:0]  busy_q, busy_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q  [NUM_SLOTS];
  logic [ADDR_WIDTH-1:0] cur_addr_d  [NUM_SLOTS];
  logic [3:0]            regs_left_q [NUM_SLOTS];
  logic [3:0]            regs_left_d [NUM_SLOTS];
  logic [BEAT_WIDTH-1:0] beat_cnt_q  [NUM_SLOTS];
  logic [BEAT_WIDTH-1:0] beat_cnt_d  [NUM_SLOTS];
  logic [BEAT_WIDTH-1:0] beats_q     [NUM_SLOTS];
  logic [BEAT_WIDTH-1:0] beats_d     [NUM_SLOTS];

  logic                  wr_valid_q, wr_valid_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [SLOT_W-1:0]     wr_slot_q, wr_slot_d;
  logic                  wr_last_q, wr_last_d;
  logic                  rsp_err_q, rsp_err_d;

  logic                  any_free;
  logic [SLOT_W-1:0]     free_slot;
  logic                  alloc_fire;
  logic [SLOT_W-1:0]     rs;
  logic [3:0]            regs_init;

  assign rs         = bus.rsp_slot;
  assign regs_init  = (4'd1 << bus.alloc_lmul) - 4'd1;
  assign alloc_fire = bus.alloc_valid & any_free & ~bus.flush;

  assign bus.alloc_ready = any_free & ~bus.flush;
  assign bus.alloc_slot  = free_slot;
  assign bus.busy        = busy_q;
  assign bus.wr_valid    = wr_valid_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_slot     = wr_slot_q;
  assign bus.wr_last     = wr_last_q;
  assign bus.rsp_err     = rsp_err_q;

  // Lowest-index free slot; scanning downward lets the lowest index win.
  always_comb begin
    any_free  = 1'b0;
    free_slot = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        any_free  = 1'b1;
        free_slot = SLOT_W'(i);
      end
    end
  end

  // Slot bookkeeping and write generation. A response only touches the slot it
  // names and an allocation only a slot that is free this cycle, so both can
  // land on the same edge without interfering.
  always_comb begin
    busy_d      = busy_q;
    cur_addr_d  = cur_addr_q;
    regs_left_d = regs_left_q;
    beat_cnt_d  = beat_cnt_q;
    beats_d     = beats_q;
    wr_valid_d  = 1'b0;
    wr_last_d   = 1'b0;
    rsp_err_d   = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_slot_d   = wr_slot_q;

    if (bus.flush) begin
      busy_d = '0;
    end else begin
      if (bus.rsp_valid) begin
        if (busy_q[rs]) begin
          wr_valid_d = 1'b1;
          wr_addr_d  = cur_addr_q[rs];
          wr_slot_d  = rs;
          if (beat_cnt_q[rs] != beats_q[rs]) begin
            beat_cnt_d[rs] = beat_cnt_q[rs] + BEAT_WIDTH'(1);
          end else if (regs_left_q[rs] != 4'd0) begin
            beat_cnt_d[rs]  = '0;
            regs_left_d[rs] = regs_left_q[rs] - 4'd1;
            cur_addr_d[rs]  = cur_addr_q[rs] + ADDR_WIDTH'(1);
          end else begin
            wr_last_d  = 1'b1;
            busy_d[rs] = 1'b0;
          end
        end else begin
          rsp_err_d = 1'b1;
        end
      end
      if (alloc_fire) begin
        busy_d[free_slot]      = 1'b1;
        cur_addr_d[free_slot]  = bus.alloc_vd;
        regs_left_d[free_slot] = regs_init;
        beat_cnt_d[free_slot]  = '0;
        beats_d[free_slot]     = bus.alloc_beats;
      end
    end
  end

  // State register; reset abandons every in-flight load at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q     <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_slot_q  <= '0;
      wr_last_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        cur_addr_q[i]  <= '0;
        regs_left_q[i] <= '0;
        beat_cnt_q[i]  <= '0;
        beats_q[i]     <= '0;
      end
    end else begin
      busy_q      <= busy_d;
      cur_addr_q  <= cur_addr_d;
      regs_left_q <= regs_left_d;
      beat_cnt_q  <= beat_cnt_d;
      beats_q     <= beats_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_slot_q   <= wr_slot_d;
      wr_last_q   <= wr_last_d;
      rsp_err_q   <= rsp_err_d;
    end
  end
endmodule
